// File: rtl/ro_measure_ctrl.sv
// Ring-oscillator frequency sweep controller: steps the divider select 0..3 and
// counts synchronised div_clk rising edges over a fixed gate window per select.
module ro_measure_ctrl #(
   parameter int GATE_CYCLES   = 1024,
   parameter int SETTLE_CYCLES = 16,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             div_clk,
   input  logic             result_ready,
   output logic [3:0]       sel,
   output logic             busy,
   output logic             result_valid,
   output logic [3:0]       result_sel,
   output logic [CNT_W-1:0] result_count,
   output logic             done
);

   localparam int MAXC  = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int CYC_W = (MAXC > 2) ? $clog2(MAXC) : 1;
   localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
   localparam logic [CYC_W-1:0] GATE_LAST   = CYC_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_COUNT, ST_REPORT, ST_DONE} state_t;

   state_t             state_q, state_d;
   logic               sync1_q, sync2_q, prev_q;
   logic [CYC_W-1:0]   cyc_q, cyc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         sel_q, sel_d;
   logic               rvalid_q, rvalid_d;
   logic [1:0]         rsel_q, rsel_d;
   logic [CNT_W-1:0]   rcount_q, rcount_d;
   logic               edge_det;
   logic [CNT_W-1:0]   cnt_inc;
   logic               done_pulse;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= div_clk;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign edge_det = sync2_q & ~prev_q;
   assign cnt_inc  = (edge_det && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cyc_q    <= '0;
         cnt_q    <= '0;
         sel_q    <= '0;
         rvalid_q <= 1'b0;
         rsel_q   <= '0;
         rcount_q <= '0;
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         rvalid_q <= rvalid_d;
         rsel_q   <= rsel_d;
         rcount_q <= rcount_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      cnt_d      = cnt_q;
      sel_d      = sel_q;
      rvalid_d   = rvalid_q;
      rsel_d     = rsel_q;
      rcount_d   = rcount_q;
      done_pulse = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               sel_d   = '0;
               cyc_d   = '0;
               cnt_d   = '0;
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (cyc_q == SETTLE_LAST) begin
               cyc_d   = '0;
               state_d = ST_COUNT;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         ST_COUNT: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
               if (cyc_q == GATE_LAST) begin
                  // the edge seen in the final gate cycle still belongs to this window
                  cyc_d    = '0;
                  rvalid_d = 1'b1;
                  rsel_d   = sel_q;
                  rcount_d = cnt_inc;
                  state_d  = ST_REPORT;
               end else begin
                  cyc_d = cyc_q + CYC_W'(1);
               end
            end
         end
         ST_REPORT: begin
            if (abort) begin
               rvalid_d = 1'b0;
               state_d  = ST_IDLE;
            end else if (result_ready) begin
               rvalid_d = 1'b0;
               if (sel_q != 2'd3) begin
                  sel_d   = sel_q + 2'd1;
                  cyc_d   = '0;
                  cnt_d   = '0;
                  state_d = ST_SETTLE;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            done_pulse = !abort;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign sel          = {2'b00, sel_q};
   assign busy         = (state_q != ST_IDLE);
   assign result_valid = rvalid_q;
   assign result_sel   = {2'b00, rsel_q};
   assign result_count = rcount_q;
   assign done         = done_pulse;

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// Bench for ro_measure_ctrl: a wide and a 4-bit-counter instance share stimulus;
// expected counts come from a history of sampled div_clk values.
module tb_ro_measure_ctrl;

   localparam int G = 100;
   localparam int S = 4;

   logic clk = 1'b0;
   logic rst, start, abort, div_clk, result_ready;
   logic [3:0]  sel_a, rsel_a, sel_b, rsel_b;
   logic        busy_a, rv_a, done_a, busy_b, rv_b, done_b;
   logic [15:0] rc_a;
   logic [3:0]  rc_b;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int div_mode = 0;
   int div_per  = 10;
   int phase    = 0;
   logic dhist [0:32767];

   ro_measure_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .div_clk(div_clk),
      .result_ready(result_ready), .sel(sel_a), .busy(busy_a), .result_valid(rv_a),
      .result_sel(rsel_a), .result_count(rc_a), .done(done_a));

   ro_measure_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .div_clk(div_clk),
      .result_ready(result_ready), .sel(sel_b), .busy(busy_b), .result_valid(rv_b),
      .result_sel(rsel_b), .result_count(rc_b), .done(done_b));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cyc < 32768) dhist[cyc] = div_clk;
      cyc = cyc + 1;
   end

   always @(negedge clk) begin
      phase = phase + 1;
      if (div_mode == 1) div_clk = 1'($urandom_range(0, 1));
      else               div_clk = ((phase % div_per) < (div_per / 2));
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
      $fatal(1);
   end

   // Rising edges of div_clk as seen after a two-sample delay, over the gate window,
   // clamped to the counter's range.
   function automatic int exp_count(input int m_first, input int w);
      int c  = 0;
      int mx = (1 << w) - 1;
      for (int m = m_first; m < m_first + G; m++)
         if (m >= 3 && dhist[m-2] === 1'b1 && dhist[m-3] === 1'b0) c++;
      return (c > mx) ? mx : c;
   endfunction

   task automatic wait_edge(input int e);
      while (cyc <= e) @(negedge clk);
   endtask

   task automatic do_start(output int base);
      @(negedge clk);
      start = 1'b1;
      base  = cyc;
      @(negedge clk);
      start = 1'b0;
      total++;
      if ({busy_a, busy_b} !== 2'b11) begin
         bad++; $display("FAIL start_busy got=%b%b exp=11", busy_a, busy_b);
      end
      total++;
      if (sel_a !== 4'd0 || sel_b !== 4'd0 || rv_a !== 1'b0) begin
         bad++; $display("FAIL start_sel got=%0d/%0d valid=%b exp=0/0 valid=0", sel_a, sel_b, rv_a);
      end
   endtask

   task automatic run_slot(input int k, input int d, input bit tied, inout int base,
                           output int got_a, output int got_b);
      int ea, eb;
      wait_edge(base + S + G - 1);
      total++;
      if (rv_a !== 1'b0 || busy_a !== 1'b1) begin
         bad++; $display("FAIL gate_len sel=%0d valid=%b busy=%b exp valid=0 busy=1", k, rv_a, busy_a);
      end
      @(negedge clk);
      ea = exp_count(base + S + 1, 16);
      eb = exp_count(base + S + 1, 4);
      got_a = int'(rc_a);
      got_b = int'(rc_b);
      total++;
      if ({rv_a, rv_b} !== 2'b11 || rsel_a !== 4'(k) || rsel_b !== 4'(k)) begin
         bad++; $display("FAIL report sel=%0d valid=%b%b rsel=%0d/%0d exp valid=11 rsel=%0d",
                         k, rv_a, rv_b, rsel_a, rsel_b, k);
      end
      total++;
      if (got_a !== ea) begin
         bad++; $display("FAIL count_a sel=%0d got=%0d exp=%0d", k, got_a, ea);
      end
      total++;
      if (got_b !== eb) begin
         bad++; $display("FAIL count_b sel=%0d got=%0d exp=%0d", k, got_b, eb);
      end
      if (!tied) result_ready = 1'b0;
      for (int i = 0; i < d; i++) begin
         @(negedge clk);
         total++;
         if (rv_a !== 1'b1 || rsel_a !== 4'(k) || rc_a !== 16'(ea) || rc_b !== 4'(eb) ||
             sel_a !== 4'(k) || busy_a !== 1'b1) begin
            bad++; $display("FAIL hold sel=%0d cyc=%0d valid=%b rsel=%0d cnt=%0d sel=%0d exp valid=1 rsel=%0d cnt=%0d",
                            k, i, rv_a, rsel_a, rc_a, sel_a, k, ea);
         end
      end
      result_ready = 1'b1;
      base = cyc;
      @(negedge clk);
      if (!tied) result_ready = 1'b0;
      total++;
      if (rv_a !== 1'b0 || rv_b !== 1'b0) begin
         bad++; $display("FAIL valid_drop sel=%0d got=%b%b exp=00", k, rv_a, rv_b);
      end
      total++;
      if (k < 3) begin
         if (sel_a !== 4'(k + 1) || busy_a !== 1'b1 || done_a !== 1'b0) begin
            bad++; $display("FAIL advance sel got=%0d busy=%b done=%b exp sel=%0d busy=1 done=0",
                            sel_a, busy_a, done_a, k + 1);
         end
      end else begin
         if (done_a !== 1'b1 || done_b !== 1'b1 || sel_a !== 4'd3) begin
            bad++; $display("FAIL done_pulse got=%b%b sel=%0d exp=11 sel=3", done_a, done_b, sel_a);
         end
      end
   endtask

   task automatic finish_sweep;
      @(negedge clk);
      total++;
      if (done_a !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0 || sel_a !== 4'd3) begin
         bad++; $display("FAIL sweep_end done=%b busy=%b%b sel=%0d exp done=0 busy=00 sel=3",
                         done_a, busy_a, busy_b, sel_a);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; abort = 1'b0; result_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (sel_a !== 4'd0 || busy_a !== 1'b0 || rv_a !== 1'b0 || rsel_a !== 4'd0 ||
          rc_a !== 16'd0 || done_a !== 1'b0 || busy_b !== 1'b0 || rc_b !== 4'd0) begin
         bad++; $display("FAIL reset_state sel=%0d busy=%b valid=%b rsel=%0d cnt=%0d done=%b exp all 0",
                         sel_a, busy_a, rv_a, rsel_a, rc_a, done_a);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_nominal;
      int base, ga, gb;
      div_mode = 0; div_per = 10; result_ready = 1'b1;
      do_start(base);
      for (int k = 0; k < 4; k++) begin
         run_slot(k, 0, 1'b1, base, ga, gb);
         total++;
         if (ga < 9 || ga > 11) begin
            bad++; $display("FAIL nominal_rate sel=%0d got=%0d exp=10+/-1", k, ga);
         end
      end
      finish_sweep();
      result_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      int base, ga, gb;
      div_mode = 1;
      do_start(base);
      for (int k = 0; k < 4; k++)
         run_slot(k, (k == 1) ? 50 : $urandom_range(0, 6), 1'b0, base, ga, gb);
      finish_sweep();
   endtask

   task automatic test_saturation;
      int base, ga, gb;
      div_mode = 0; div_per = 4; result_ready = 1'b1;
      do_start(base);
      for (int k = 0; k < 4; k++) begin
         run_slot(k, 0, 1'b1, base, ga, gb);
         total++;
         if (gb !== 15) begin
            bad++; $display("FAIL saturate sel=%0d got=%0d exp=15", k, gb);
         end
      end
      finish_sweep();
      result_ready = 1'b0;
   endtask

   task automatic test_abort;
      int base, ga, gb;
      bit ok;
      div_mode = 1; result_ready = 1'b1;
      do_start(base);
      run_slot(0, 0, 1'b1, base, ga, gb);
      run_slot(1, 0, 1'b1, base, ga, gb);
      wait_edge(base + S + 49);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      total++;
      if (busy_a !== 1'b0 || rv_a !== 1'b0 || done_a !== 1'b0 || sel_a !== 4'd2) begin
         bad++; $display("FAIL abort_count busy=%b valid=%b done=%b sel=%0d exp busy=0 valid=0 done=0 sel=2",
                         busy_a, rv_a, done_a, sel_a);
      end
      ok = 1'b1;
      for (int i = 0; i < G + 10; i++) begin
         @(negedge clk);
         if (rv_a !== 1'b0 || done_a !== 1'b0 || busy_a !== 1'b0) ok = 1'b0;
      end
      total++;
      if (ok !== 1'b1) begin
         bad++; $display("FAIL abort_quiet got=%b exp=1", ok);
      end
      do_start(base);
      for (int k = 0; k < 4; k++) run_slot(k, 0, 1'b1, base, ga, gb);
      finish_sweep();
      result_ready = 1'b0;
   endtask

   task automatic test_start_busy;
      int base, ga, gb;
      div_mode = 1; result_ready = 1'b1;
      do_start(base);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 4; k++) run_slot(k, 0, 1'b1, base, ga, gb);
      finish_sweep();
      result_ready = 1'b0;
   endtask

   task automatic test_abort_transfer;
      int base, ga, gb;
      div_mode = 1;
      do_start(base);
      run_slot(0, 2, 1'b0, base, ga, gb);
      wait_edge(base + S + G);
      abort = 1'b1; result_ready = 1'b1;
      @(negedge clk);
      abort = 1'b0; result_ready = 1'b0;
      total++;
      if (busy_a !== 1'b0 || rv_a !== 1'b0 || sel_a !== 4'd1 || done_a !== 1'b0) begin
         bad++; $display("FAIL abort_xfer busy=%b valid=%b sel=%0d done=%b exp busy=0 valid=0 sel=1 done=0",
                         busy_a, rv_a, sel_a, done_a);
      end
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      total++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
         bad++; $display("FAIL start_abort_idle got=%b%b exp=00", busy_a, busy_b);
      end
   endtask

   task automatic test_reset_report;
      int base, ga, gb;
      div_mode = 1;
      do_start(base);
      run_slot(0, 0, 1'b0, base, ga, gb);
      wait_edge(base + S + G);
      total++;
      if (rv_a !== 1'b1) begin
         bad++; $display("FAIL pre_reset_valid got=%b exp=1", rv_a);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (sel_a !== 4'd0 || busy_a !== 1'b0 || rv_a !== 1'b0 || rsel_a !== 4'd0 ||
          rc_a !== 16'd0 || done_a !== 1'b0 || rv_b !== 1'b0 || rc_b !== 4'd0) begin
         bad++; $display("FAIL async_reset sel=%0d busy=%b valid=%b rsel=%0d cnt=%0d done=%b exp all 0",
                         sel_a, busy_a, rv_a, rsel_a, rc_a, done_a);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      do_start(base);
      for (int k = 0; k < 4; k++) run_slot(k, $urandom_range(0, 3), 1'b0, base, ga, gb);
      finish_sweep();
   endtask

   initial begin
      div_clk = 1'b0;
      test_reset();
      test_nominal();
      test_backpressure();
      test_saturation();
      test_abort();
      test_start_busy();
      test_abort_transfer();
      test_reset_report();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
